tt_um_ac3e_io_engine: RTL

// - Parametrised Tiny Tapeout user top. Successor to the fixed combinational inverter top.
// - uo_out is driven by a registered data engine with four modes: INV, COUNT, LFSR and EDGE.
// - Mode, run and load controls arrive on uio_in[3:0] through a synchroniser; status leaves on uio_out[7:4].

---
 rtl/tt_ac3e_pkg.sv | 27 ++
 rtl/ac3e_sync.sv | 30 +++
 rtl/tt_um_ac3e_io_engine.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/tt_ac3e_pkg.sv
// Shared constants and helpers for the AC3E Tiny Tapeout I/O engine.
package tt_ac3e_pkg;

   // Engine mode encodings as seen on synced uio_in[1:0]
   localparam logic [1:0] MODE_INV   = 2'b00;
   localparam logic [1:0] MODE_COUNT = 2'b01;
   localparam logic [1:0] MODE_LFSR  = 2'b10;
   localparam logic [1:0] MODE_EDGE  = 2'b11;

   // Default Galois feedback mask (maximal length for 8 bits)
   localparam logic [7:0] LFSR_TAPS_DEF = 8'hB8;

   // Upper nibble of uio is output (status), lower nibble is input (control)
   localparam logic [7:0] UIO_OE_MASK = 8'hF0;

   // One Galois LFSR shift; a zero state stays zero
   function automatic logic [7:0] lfsr_next(input logic [7:0] d, input logic [7:0] taps);
      logic [7:0] fb;
      if (d[0]) begin
         fb = taps;
      end else begin
         fb = 8'h00;
      end
      return (d >> 1) ^ fb;
   endfunction

endpackage

// File: rtl/ac3e_sync.sv
// N-flop synchroniser for slow asynchronous control inputs.
module ac3e_sync #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_stg [STAGES];

   // Shift the raw input through the synchroniser chain
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            r_stg[i] <= '0;
         end
      end else begin
         r_stg[0] <= i_d;
         for (int i = 1; i < STAGES; i++) begin
            r_stg[i] <= r_stg[i-1];
         end
      end
   end

   assign o_q = r_stg[STAGES-1];

endmodule

// File: rtl/tt_um_ac3e_io_engine.sv
// Tiny Tapeout user top: registered data engine with INV/COUNT/LFSR/EDGE modes.
module tt_um_ac3e_io_engine
   import tt_ac3e_pkg::*;
#(
   parameter int             WIDTH       = 8,
   parameter int             SYNC_STAGES = 2,
   parameter int             PRESCALE    = 1,
   parameter logic [7:0]     LFSR_TAPS   = LFSR_TAPS_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int             PCW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PCW-1:0] P_LAST = PCW'(PRESCALE - 1);

   // Synchronised controls
   logic [3:0]       w_ctl;
   logic [1:0]       w_mode;
   logic             w_load;
   logic             w_run;

   // Pulse detectors
   logic [1:0]       r_mode_prev;
   logic             r_load_prev;
   logic             w_load_p;
   logic             w_mode_chg;

   // Data sampling
   logic [WIDTH-1:0] r_ui_q;
   logic [WIDTH-1:0] r_ui_prev;

   // Prescaler
   logic [PCW-1:0]   r_pcnt;
   logic [PCW-1:0]   w_pcnt_nxt;
   logic             w_tick;

   // Engine
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] w_d_nxt;
   logic [WIDTH-1:0] w_lfsr;
   logic             w_wrap_nxt;
   logic             r_tick;
   logic             r_wrap;

   logic             w_unused;

   assign w_unused = &{ena, uio_in[7:4], ui_in, 1'b0};

   ac3e_sync #(
      .WIDTH  (4),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_d     (uio_in[3:0]),
      .o_q     (w_ctl)
   );

   assign w_mode     = w_ctl[1:0];
   assign w_load     = w_ctl[2];
   assign w_run      = w_ctl[3];
   assign w_load_p   = w_load & ~r_load_prev;
   assign w_mode_chg = (w_mode != r_mode_prev);

   // Register data input and keep its previous value for rising-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ui_q    <= '0;
         r_ui_prev <= '0;
      end else begin
         r_ui_q    <= ui_in[WIDTH-1:0];
         r_ui_prev <= r_ui_q;
      end
   end

   // Remember last synced load and mode to form one-cycle pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_load_prev <= 1'b0;
         r_mode_prev <= MODE_INV;
      end else begin
         r_load_prev <= w_load;
         r_mode_prev <= w_mode;
      end
   end

   // Prescaler next count and tick: wraps in the tick cycle, parked at 0 while idle
   always_comb begin
      w_tick     = 1'b0;
      w_pcnt_nxt = r_pcnt;
      if (!w_run) begin
         w_pcnt_nxt = '0;
      end else if (r_pcnt == P_LAST) begin
         w_tick     = 1'b1;
         w_pcnt_nxt = '0;
      end else begin
         w_pcnt_nxt = r_pcnt + PCW'(1);
      end
   end

   // Prescaler count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= w_pcnt_nxt;
      end
   end

   assign w_lfsr = WIDTH'(lfsr_next(8'(r_d), 8'(LFSR_TAPS[WIDTH-1:0])));

   // Engine next state: mode change beats load, load beats tick
   always_comb begin
      w_d_nxt    = r_d;
      w_wrap_nxt = 1'b0;
      if (w_mode_chg) begin
         w_d_nxt = '0;
      end else begin
         case (w_mode)
            MODE_INV: begin
               w_d_nxt = ~r_ui_q;
            end
            MODE_COUNT: begin
               if (w_load_p) begin
                  w_d_nxt = r_ui_q;
               end else if (w_tick) begin
                  w_d_nxt    = r_d + WIDTH'(1);
                  w_wrap_nxt = &r_d;
               end else begin
                  w_d_nxt = r_d;
               end
            end
            MODE_LFSR: begin
               if (w_load_p) begin
                  if (r_ui_q == '0) begin
                     w_d_nxt = WIDTH'(1);
                  end else begin
                     w_d_nxt = r_ui_q;
                  end
               end else if (w_tick) begin
                  w_d_nxt = w_lfsr;
               end else begin
                  w_d_nxt = r_d;
               end
            end
            MODE_EDGE: begin
               if (w_load_p) begin
                  w_d_nxt = '0;
               end else begin
                  w_d_nxt = r_d | (r_ui_q & ~r_ui_prev);
               end
            end
            default: begin
               w_d_nxt = r_d;
            end
         endcase
      end
   end

   // Data register and registered status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d    <= '0;
         r_tick <= 1'b0;
         r_wrap <= 1'b0;
      end else begin
         r_d    <= w_d_nxt;
         r_tick <= w_tick;
         r_wrap <= w_wrap_nxt;
      end
   end

   assign uo_out  = 8'(r_d);
   assign uio_out = {w_mode, r_wrap, r_tick, 4'b0000};
   assign uio_oe  = UIO_OE_MASK;

endmodule
